st7789_spi_sink: RTL and testbench

Display-side receiver for the ST7789V3 4-wire SPI protocol (Mode 0, MSB first, DC-qualified bytes). It deserialises the bus and decodes CASET, RASET and RAMWR. RAMWR pixel data is written into a 320x172 RGB565 framebuffer using the same linear addressing as the display driver's read port. It is used as a loopback/capture target for the display driver on-chip and as the scoreboard front-end in display-path benches.

---
 rtl/st7789_spi_sink_pkg.sv | 36 +++
 rtl/st7789_spi_sink_spi_byte_rx.sv | 69 ++++++
 rtl/st7789_spi_sink.sv | 160 ++++++++++++++++
 tb/tb_st7789_spi_sink.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st7789_spi_sink_pkg.sv
// Shared constants and types for the ST7789 SPI sink: panel geometry, default
// window, opcodes and decoder FSM states.
package st7789_spi_sink_pkg;

    localparam logic [15:0] H_RES      = 16'd320;
    localparam logic [15:0] V_RES      = 16'd172;
    localparam logic [15:0] ROW_OFFSET = 16'd34;
    localparam logic [15:0] PIX_COUNT  = H_RES * V_RES;

    localparam logic [15:0] DEF_XS = 16'd0;
    localparam logic [15:0] DEF_XE = H_RES - 16'd1;
    localparam logic [15:0] DEF_YS = ROW_OFFSET;
    localparam logic [15:0] DEF_YE = ROW_OFFSET + V_RES - 16'd1;

    localparam logic [7:0] OP_SLPOUT = 8'h11;
    localparam logic [7:0] OP_DISPON = 8'h29;
    localparam logic [7:0] OP_CASET  = 8'h2A;
    localparam logic [7:0] OP_RASET  = 8'h2B;
    localparam logic [7:0] OP_RAMWR  = 8'h2C;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_CASET_P,
        ST_RASET_P,
        ST_RAMWR,
        ST_IGNORE
    } dec_state_e;

    // (y - ROW_OFFSET) * 320 built from shifts; wraps modulo 2^16 for rows above the panel
    function automatic logic [15:0] row_base_of(input logic [15:0] y);
        logic [15:0] d;
        d = y - ROW_OFFSET;
        return (d << 8) + (d << 6);
    endfunction

endpackage

// File: rtl/st7789_spi_sink_spi_byte_rx.sv
// SPI Mode 0 byte deserialiser: synchronises the bus into clk, detects SCK
// rises and emits one {dc, byte} strobe per 8 bits while CS is low.
module spi_byte_rx
    import st7789_spi_sink_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_n_i,
    input  logic       spi_sck_i,
    input  logic       spi_mosi_i,
    input  logic       spi_dc_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_dc_o
);

    logic [2:0] cs_s_q;
    logic [2:0] sck_s_q;
    logic [2:0] mosi_s_q;
    logic [2:0] dc_s_q;
    logic       rise_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       byte_dc_q;

    // Stage 3 of each chain stays aligned with the registered rise pulse, so
    // mosi/dc/cs are read as they were when SCK was first seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s_q       <= 3'b111;
            sck_s_q      <= 3'b000;
            mosi_s_q     <= 3'b000;
            dc_s_q       <= 3'b000;
            rise_q       <= 1'b0;
            shift_q      <= 7'd0;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_dc_q    <= 1'b0;
        end else begin
            cs_s_q       <= {cs_s_q[1:0], spi_cs_n_i};
            sck_s_q      <= {sck_s_q[1:0], spi_sck_i};
            mosi_s_q     <= {mosi_s_q[1:0], spi_mosi_i};
            dc_s_q       <= {dc_s_q[1:0], spi_dc_i};
            rise_q       <= sck_s_q[1] & ~sck_s_q[2];
            byte_valid_q <= 1'b0;
            if (cs_s_q[2]) begin
                bit_cnt_q <= 3'd0;
            end else if (rise_q) begin
                shift_q <= {shift_q[5:0], mosi_s_q[2]};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q    <= 3'd0;
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q, mosi_s_q[2]};
                    byte_dc_q    <= dc_s_q[2];
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign byte_dc_o    = byte_dc_q;

endmodule

// File: rtl/st7789_spi_sink.sv
// ST7789 SPI receiver: decodes CASET/RASET/RAMWR and turns RAMWR pixel bytes
// into framebuffer writes with linear addressing.
module st7789_spi_sink
    import st7789_spi_sink_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_dc,
    output logic        fb_we,
    output logic [15:0] fb_waddr,
    output logic [15:0] fb_wdata,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        ramwr_active,
    output logic        oob_pixel,
    output logic        frame_done
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;

    spi_byte_rx u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n_i   (spi_cs_n),
        .spi_sck_i    (spi_sck),
        .spi_mosi_i   (spi_mosi),
        .spi_dc_i     (spi_dc),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .byte_dc_o    (byte_dc)
    );

    dec_state_e  state_q;
    logic [1:0]  par_cnt_q;
    logic [23:0] par_q;
    logic [15:0] xs_q, xe_q, ys_q, ye_q;
    logic [15:0] x_q, y_q, row_base_q;
    logic        hi_phase_q;
    logic [7:0]  hi_byte_q;
    logic        fb_we_q, cmd_valid_q, ramwr_active_q, oob_q, frame_done_q;
    logic [15:0] fb_waddr_q, fb_wdata_q;
    logic [7:0]  cmd_byte_q;
    logic        in_fb;

    assign in_fb = (x_q < H_RES) && (y_q >= ROW_OFFSET) && (y_q < ROW_OFFSET + V_RES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_CMD;
            par_cnt_q      <= 2'd0;
            par_q          <= 24'd0;
            xs_q           <= DEF_XS;
            xe_q           <= DEF_XE;
            ys_q           <= DEF_YS;
            ye_q           <= DEF_YE;
            x_q            <= DEF_XS;
            y_q            <= DEF_YS;
            row_base_q     <= 16'd0;
            hi_phase_q     <= 1'b1;
            hi_byte_q      <= 8'd0;
            fb_we_q        <= 1'b0;
            fb_waddr_q     <= 16'd0;
            fb_wdata_q     <= 16'd0;
            cmd_valid_q    <= 1'b0;
            cmd_byte_q     <= 8'd0;
            ramwr_active_q <= 1'b0;
            oob_q          <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            cmd_valid_q  <= 1'b0;
            oob_q        <= 1'b0;
            frame_done_q <= 1'b0;
            if (byte_valid && !byte_dc) begin
                cmd_valid_q    <= 1'b1;
                cmd_byte_q     <= byte_data;
                par_cnt_q      <= 2'd0;
                ramwr_active_q <= (byte_data == OP_RAMWR);
                case (byte_data)
                    OP_CASET: state_q <= ST_CASET_P;
                    OP_RASET: state_q <= ST_RASET_P;
                    OP_RAMWR: begin
                        state_q    <= ST_RAMWR;
                        x_q        <= xs_q;
                        y_q        <= ys_q;
                        row_base_q <= row_base_of(ys_q);
                        hi_phase_q <= 1'b1;
                    end
                    default:  state_q <= ST_IGNORE;
                endcase
            end else if (byte_valid) begin
                case (state_q)
                    ST_CASET_P, ST_RASET_P: begin
                        par_cnt_q <= par_cnt_q + 2'd1;
                        case (par_cnt_q)
                            2'd0: par_q[23:16] <= byte_data;
                            2'd1: par_q[15:8]  <= byte_data;
                            2'd2: par_q[7:0]   <= byte_data;
                            default: begin
                                // Window only changes once all four bytes are in
                                if (state_q == ST_CASET_P) begin
                                    xs_q <= par_q[23:8];
                                    xe_q <= {par_q[7:0], byte_data};
                                end else begin
                                    ys_q <= par_q[23:8];
                                    ye_q <= {par_q[7:0], byte_data};
                                end
                                state_q <= ST_CMD;
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        if (hi_phase_q) begin
                            hi_byte_q  <= byte_data;
                            hi_phase_q <= 1'b0;
                        end else begin
                            hi_phase_q <= 1'b1;
                            fb_wdata_q <= {hi_byte_q, byte_data};
                            if (in_fb) begin
                                fb_we_q    <= 1'b1;
                                fb_waddr_q <= row_base_q + x_q;
                            end else begin
                                oob_q <= 1'b1;
                            end
                            if (x_q == xe_q) begin
                                x_q <= xs_q;
                                if (y_q == ye_q) begin
                                    y_q          <= ys_q;
                                    row_base_q   <= row_base_of(ys_q);
                                    frame_done_q <= 1'b1;
                                end else begin
                                    y_q        <= y_q + 16'd1;
                                    row_base_q <= row_base_q + H_RES;
                                end
                            end else begin
                                x_q <= x_q + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fb_we        = fb_we_q;
    assign fb_waddr     = fb_waddr_q;
    assign fb_wdata     = fb_wdata_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_byte     = cmd_byte_q;
    assign ramwr_active = ramwr_active_q;
    assign oob_pixel    = oob_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_st7789_spi_sink.sv
// Directed bench for st7789_spi_sink: drives SPI bytes at SCK = clk/4 and
// checks command decode, window addressing, out-of-bounds drops and reset.
module tb_st7789_spi_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_dc = 1'b0;
    logic        fb_we;
    logic [15:0] fb_waddr;
    logic [15:0] fb_wdata;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        ramwr_active;
    logic        oob_pixel;
    logic        frame_done;

    st7789_spi_sink dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_dc       (spi_dc),
        .fb_we        (fb_we),
        .fb_waddr     (fb_waddr),
        .fb_wdata     (fb_wdata),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .ramwr_active (ramwr_active),
        .oob_pixel    (oob_pixel),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned cmd_cyc = 0;

    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [7:0]  cmd_q[$];
    int          oob_cnt = 0;
    int          fd_cnt = 0;
    logic        fd_we = 1'b0;
    logic [15:0] fd_addr = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_we) begin
            wa_q.push_back(fb_waddr);
            wd_q.push_back(fb_wdata);
        end
        if (cmd_valid) begin
            cmd_q.push_back(cmd_byte);
            cmd_cyc = cyc;
        end
        if (oob_pixel) oob_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_we   = fb_we;
            fd_addr = fb_waddr;
        end
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        cmd_q.delete();
        oob_cnt = 0;
        fd_cnt  = 0;
        fd_we   = 1'b0;
        fd_addr = 16'd0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        spi_sck  = 1'b0;
        spi_mosi = b;
        settle(2);
        spi_sck  = 1'b1;
        rise_cyc = cyc;
        settle(2);
        spi_sck  = 1'b0;
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] data, input int n);
        spi_cs_n = 1'b0;
        spi_dc   = dc;
        for (int i = 0; i < n; i++) spi_bit(data[7-i]);
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] data);
        send_bits(dc, data, 8);
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_byte(1'b1, p[15:8]);
        send_byte(1'b1, p[7:0]);
    endtask

    task automatic send_window(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
        send_byte(1'b0, op);
        send_byte(1'b1, s[15:8]);
        send_byte(1'b1, s[7:0]);
        send_byte(1'b1, e[15:8]);
        send_byte(1'b1, e[7:0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        settle(4);
        checks++;
        if ({fb_we, fb_waddr, fb_wdata, cmd_valid, cmd_byte, ramwr_active, oob_pixel, frame_done} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h cmd_v=%b cmd=%h act=%b oob=%b fd=%b, want all 0",
                     fb_we, fb_waddr, fb_wdata, cmd_valid, cmd_byte, ramwr_active, oob_pixel, frame_done);
        end
        rst_n = 1'b1;
        settle(4);
    endtask

    task automatic test_latency();
        clear_mon();
        send_byte(1'b0, 8'h11);
        settle(8);
        checks++;
        if (cmd_q.size() !== 1 || (cmd_q.size() == 1 && cmd_q[0] !== 8'h11)) begin
            errors++;
            $display("FAIL slpout_cmd: got %0d cmds (first %h), want 1 cmd 11", cmd_q.size(),
                     cmd_q.size() > 0 ? cmd_q[0] : 8'h00);
        end
        checks++;
        if (cmd_cyc - rise_cyc !== 5) begin
            errors++;
            $display("FAIL cmd_latency: got %0d, want 5 cycles from SCK rise drive", cmd_cyc - rise_cyc);
        end
        checks++;
        if (ramwr_active !== 1'b0) begin
            errors++;
            $display("FAIL slpout_active: got %b, want 0", ramwr_active);
        end
    endtask

    task automatic test_partial_caset();
        clear_mon();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h29);
        settle(8);
        checks++;
        if (cmd_q.size() !== 2 || (cmd_q.size() == 2 && (cmd_q[0] !== 8'h2A || cmd_q[1] !== 8'h29))) begin
            errors++;
            $display("FAIL partial_caset_cmds: got %0d cmds last=%h, want 2 cmds 2a,29", cmd_q.size(), cmd_byte);
        end
        clear_mon();
        send_byte(1'b0, 8'h2C);
        send_pixel(16'hABCD);
        settle(8);
        checks++;
        if (wa_q.size() !== 1 || (wa_q.size() == 1 && (wa_q[0] !== 16'd0 || wd_q[0] !== 16'hABCD))) begin
            errors++;
            $display("FAIL partial_caset_pixel: got %0d writes addr=%0d data=%h, want 1 write addr 0 data abcd",
                     wa_q.size(), fb_waddr, fb_wdata);
        end
        checks++;
        if (ramwr_active !== 1'b1 || oob_cnt !== 0) begin
            errors++;
            $display("FAIL ramwr_rise: got active=%b oob=%0d, want active=1 oob=0", ramwr_active, oob_cnt);
        end
        send_byte(1'b0, 8'h29);
        settle(8);
        checks++;
        if (ramwr_active !== 1'b0) begin
            errors++;
            $display("FAIL ramwr_fall: got %b, want 0", ramwr_active);
        end
    endtask

    task automatic test_window();
        logic [15:0] exp_a [7];
        exp_a = '{16'd10, 16'd11, 16'd12, 16'd330, 16'd331, 16'd332, 16'd10};
        send_window(8'h2A, 16'd10, 16'd12);
        send_window(8'h2B, 16'd34, 16'd35);
        send_byte(1'b0, 8'h2C);
        settle(4);
        clear_mon();
        for (int i = 0; i < 7; i++) send_pixel(16'h1000 + 16'(i));
        settle(8);
        checks++;
        if (wa_q.size() !== 7) begin
            errors++;
            $display("FAIL window_count: got %0d writes, want 7", wa_q.size());
        end
        for (int i = 0; i < 7 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL window_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, wa_q[i], wd_q[i], exp_a[i], 16'h1000 + 16'(i));
            end
        end
        checks++;
        if (fd_cnt !== 1 || fd_we !== 1'b1 || fd_addr !== 16'd332) begin
            errors++;
            $display("FAIL window_frame_done: got cnt=%0d we=%b addr=%0d, want cnt=1 we=1 addr=332",
                     fd_cnt, fd_we, fd_addr);
        end
    endtask

    task automatic test_oob_top();
        logic [15:0] exp_a [8];
        exp_a = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd320, 16'd321, 16'd322, 16'd323};
        send_window(8'h2A, 16'd0, 16'd3);
        send_window(8'h2B, 16'd30, 16'd35);
        send_byte(1'b0, 8'h2C);
        settle(4);
        clear_mon();
        for (int i = 0; i < 24; i++) send_pixel(16'(i));
        settle(8);
        checks++;
        if (oob_cnt !== 16 || wa_q.size() !== 8) begin
            errors++;
            $display("FAIL oob_top_counts: got oob=%0d writes=%0d, want oob=16 writes=8", oob_cnt, wa_q.size());
        end
        for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== 16'(16 + i)) begin
                errors++;
                $display("FAIL oob_top_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, wa_q[i], wd_q[i], exp_a[i], 16'(16 + i));
            end
        end
        checks++;
        if (fd_cnt !== 1 || fd_addr !== 16'd323) begin
            errors++;
            $display("FAIL oob_top_frame_done: got cnt=%0d addr=%0d, want cnt=1 addr=323", fd_cnt, fd_addr);
        end
    endtask

    task automatic test_bottom_edge();
        send_window(8'h2A, 16'd318, 16'd320);
        send_window(8'h2B, 16'd205, 16'd206);
        send_byte(1'b0, 8'h2C);
        settle(4);
        clear_mon();
        for (int i = 0; i < 6; i++) send_pixel(16'hC000 + 16'(i));
        settle(8);
        checks++;
        if (wa_q.size() !== 2 || oob_cnt !== 4) begin
            errors++;
            $display("FAIL bottom_counts: got writes=%0d oob=%0d, want writes=2 oob=4", wa_q.size(), oob_cnt);
        end
        checks++;
        if (wa_q.size() == 2 && (wa_q[0] !== 16'd55038 || wa_q[1] !== 16'd55039 || wd_q[1] !== 16'hC001)) begin
            errors++;
            $display("FAIL bottom_addrs: got %0d,%0d data1=%h, want 55038,55039 data1=c001", wa_q[0], wa_q[1], wd_q[1]);
        end
        checks++;
        if (fd_cnt !== 1 || fd_we !== 1'b0) begin
            errors++;
            $display("FAIL bottom_frame_done: got cnt=%0d we=%b, want cnt=1 we=0", fd_cnt, fd_we);
        end
    endtask

    task automatic test_partial_byte();
        clear_mon();
        send_bits(1'b0, 8'h2B, 5);
        settle(2);
        spi_cs_n = 1'b1;
        settle(8);
        send_byte(1'b0, 8'h2C);
        settle(8);
        checks++;
        if (cmd_q.size() !== 1 || (cmd_q.size() == 1 && cmd_q[0] !== 8'h2C)) begin
            errors++;
            $display("FAIL partial_byte: got %0d cmds last=%h, want 1 cmd 2c", cmd_q.size(), cmd_byte);
        end
    endtask

    task automatic test_reset_mid();
        send_window(8'h2A, 16'd5, 16'd6);
        send_window(8'h2B, 16'd34, 16'd35);
        send_byte(1'b0, 8'h2C);
        clear_mon();
        send_pixel(16'h5555);
        settle(6);
        checks++;
        if (wa_q.size() !== 1 || (wa_q.size() == 1 && wa_q[0] !== 16'd5)) begin
            errors++;
            $display("FAIL pre_reset_write: got %0d writes addr=%0d, want 1 write addr 5", wa_q.size(), fb_waddr);
        end
        send_byte(1'b1, 8'hAA);
        send_bits(1'b1, 8'h55, 3);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_we, fb_waddr, fb_wdata, cmd_valid, cmd_byte, ramwr_active, oob_pixel, frame_done} !== 45'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got addr=%0d data=%h cmd=%h act=%b, want all 0",
                     fb_waddr, fb_wdata, cmd_byte, ramwr_active);
        end
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        settle(3);
        rst_n = 1'b1;
        clear_mon();
        settle(20);
        checks++;
        if (wa_q.size() !== 0 || cmd_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got writes=%0d cmds=%0d, want 0 and 0", wa_q.size(), cmd_q.size());
        end
        send_byte(1'b0, 8'h2C);
        send_pixel(16'hBEEF);
        settle(8);
        checks++;
        if (wa_q.size() !== 1 || (wa_q.size() == 1 && (wa_q[0] !== 16'd0 || wd_q[0] !== 16'hBEEF))) begin
            errors++;
            $display("FAIL post_reset_pixel: got %0d writes addr=%0d data=%h, want 1 write addr 0 data beef",
                     wa_q.size(), fb_waddr, fb_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_partial_caset();
        test_window();
        test_oob_top();
        test_bottom_edge();
        test_partial_byte();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
